// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the mul8_seq_ctrl sequencer.
// State encoding is fixed: PPk carries the value k+1, so a PP state's value
// is also the index of the nibble pair that follows it.
package mul8_seq_pkg;

  localparam int IN_W  = 8;
  localparam int NIB_W = 4;
  localparam int OUT_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_PP0  = PP0;
  localparam logic [2:0] ST_PP1  = PP1;
  localparam logic [2:0] ST_PP2  = PP2;
  localparam logic [2:0] ST_PP3  = PP3;
  localparam logic [2:0] ST_DONE = DONE;

  localparam logic [3:0] SHIFT_PP0 = 4'd0;
  localparam logic [3:0] SHIFT_PP1 = 4'd4;
  localparam logic [3:0] SHIFT_PP2 = 4'd4;
  localparam logic [3:0] SHIFT_PP3 = 4'd8;

  // Bit k is set when nibble pair k (PP0..PP3 order) has both nibbles nonzero.
  function automatic logic [3:0] pairMask(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] m;
    m[0] = (a[3:0] != 4'd0) && (b[3:0] != 4'd0);
    m[1] = (a[7:4] != 4'd0) && (b[3:0] != 4'd0);
    m[2] = (a[3:0] != 4'd0) && (b[7:4] != 4'd0);
    m[3] = (a[7:4] != 4'd0) && (b[7:4] != 4'd0);
    return m;
  endfunction

  // First PP state at or after pair index fromIdx whose pair is nonzero, else DONE.
  function automatic logic [2:0] nextPpState(input logic [3:0] mask, input logic [2:0] fromIdx);
    logic [2:0] result;
    result = ST_DONE;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= fromIdx)) result = ST_PP0 + 3'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshakes plus the shared nibble-multiplier connection.
// slave: the sequencer; master: request source, consumer and multiplier.
interface mul8_seq_ctrl_if;
  import mul8_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic [NIB_W-1:0] mul_a;
  logic [NIB_W-1:0] mul_b;
  logic [IN_W-1:0]  mul_p;
  logic             busy;

  modport slave (
    input  in_valid, a, b, out_ready, mul_p,
    output in_ready, out_valid, product, mul_a, mul_b, busy
  );

  modport master (
    output in_valid, a, b, out_ready, mul_p,
    input  in_ready, out_valid, product, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl_pp_select_shift.sv
// Picks the nibble pair and partial-product shift for the current state.
// Outside PP0..PP3 the multiplier operands are held at zero.
module pp_select_shift
  import mul8_seq_pkg::*;
(
  input  logic [2:0]       i_state,
  input  logic [IN_W-1:0]  i_aq,
  input  logic [IN_W-1:0]  i_bq,
  output logic [NIB_W-1:0] o_mul_a,
  output logic [NIB_W-1:0] o_mul_b,
  output logic [3:0]       o_shift
);

  // Route the nibble pair belonging to the active PP state.
  always_comb begin
    o_mul_a = '0;
    o_mul_b = '0;
    o_shift = '0;
    case (i_state)
      ST_PP0: begin o_mul_a = i_aq[3:0]; o_mul_b = i_bq[3:0]; o_shift = SHIFT_PP0; end
      ST_PP1: begin o_mul_a = i_aq[7:4]; o_mul_b = i_bq[3:0]; o_shift = SHIFT_PP1; end
      ST_PP2: begin o_mul_a = i_aq[3:0]; o_mul_b = i_bq[7:4]; o_shift = SHIFT_PP2; end
      ST_PP3: begin o_mul_a = i_aq[7:4]; o_mul_b = i_bq[7:4]; o_shift = SHIFT_PP3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned sequential multiplier built on one shared external 4x4
// multiplier. Optional macro MUL8_SEQ_ZERO_SKIP_EN skips nibble pairs that
// contain a zero nibble (and goes straight to DONE for a zero operand).
module mul8_seq_ctrl
  import mul8_seq_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  mul8_seq_ctrl_if.slave bus
);

  logic [2:0]       r_state;
  logic [2:0]       w_nextState;
  logic [IN_W-1:0]  r_aq;
  logic [IN_W-1:0]  r_bq;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_product;
  logic [NIB_W-1:0] w_mulA;
  logic [NIB_W-1:0] w_mulB;
  logic [3:0]       w_shift;
  logic [OUT_W-1:0] w_ppExt;
  logic [OUT_W-1:0] w_accSum;
  logic             w_accept;
  logic             w_inPp;

  pp_select_shift u_sel (
    .i_state (r_state),
    .i_aq    (r_aq),
    .i_bq    (r_bq),
    .o_mul_a (w_mulA),
    .o_mul_b (w_mulB),
    .o_shift (w_shift)
  );

  assign w_ppExt  = {8'd0, bus.mul_p} << w_shift;
  assign w_accSum = r_acc + w_ppExt;
  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_inPp   = (r_state >= ST_PP0) && (r_state <= ST_PP3);

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.product   = r_product;
  assign bus.mul_a     = w_mulA;
  assign bus.mul_b     = w_mulB;

  // Sequence IDLE -> PP states -> DONE -> IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef MUL8_SEQ_ZERO_SKIP_EN
          w_nextState = nextPpState(pairMask(bus.a, bus.b), 3'd0);
`else
          w_nextState = ST_PP0;
`endif
        end
      end
      ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
`ifdef MUL8_SEQ_ZERO_SKIP_EN
        w_nextState = nextPpState(pairMask(r_aq, r_bq), r_state);
`else
        w_nextState = r_state + 3'd1;
`endif
      end
      ST_DONE: begin
        if (bus.out_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, operand capture, accumulation and result latch on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_aq      <= '0;
      r_bq      <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_aq  <= bus.a;
        r_bq  <= bus.b;
        r_acc <= '0;
      end else if (w_inPp) begin
        r_acc <= w_accSum;
      end
      if ((r_state != ST_DONE) && (w_nextState == ST_DONE)) begin
        r_product <= w_accept ? '0 : w_accSum;
      end
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: directed cases followed by random
// operations, checked against products and nibble-pair schedules derived
// from plain arithmetic. Honors MUL8_SEQ_ZERO_SKIP_EN like the design.
module tb_mul8_seq_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] lastProduct;

  mul8_seq_ctrl_if bus ();

  mul8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational 4x4 multiplier.
  assign bus.mul_p = {4'd0, bus.mul_a} * {4'd0, bus.mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation starting from an IDLE negedge and ends on the
  // negedge after the result handshake (back in IDLE).
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input int holdCycles, input bit noise);
    logic [3:0] expA[$];
    logic [3:0] expB[$];
    logic [15:0] expP;
    logic [3:0] an;
    logic [3:0] bn;
    expP = 16'(opA) * 16'(opB);
    for (int p = 0; p < 4; p++) begin
      an = (p % 2 == 1) ? opA[7:4] : opA[3:0];
      bn = (p >= 2)     ? opB[7:4] : opB[3:0];
`ifdef MUL8_SEQ_ZERO_SKIP_EN
      if (an != 4'd0 && bn != 4'd0) begin
        expA.push_back(an);
        expB.push_back(bn);
      end
`else
      expA.push_back(an);
      expB.push_back(bn);
`endif
    end

    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_product", 32'(bus.product), 32'(lastProduct));
    bus.in_valid  = 1'b1;
    bus.a         = opA;
    bus.b         = opB;
    bus.out_ready = (holdCycles == 0);
    @(negedge clk);

    for (int k = 0; k < expA.size(); k++) begin
      bus.in_valid = noise;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      checkOutput("pp_mul_a", 32'(bus.mul_a), 32'(expA[k]));
      checkOutput("pp_mul_b", 32'(bus.mul_b), 32'(expB[k]));
      checkOutput("pp_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("pp_busy", 32'(bus.busy), 32'd1);
      checkOutput("pp_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    bus.in_valid = noise;
    checkOutput("done_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("done_product", 32'(bus.product), 32'(expP));
    checkOutput("done_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("done_mul_a", 32'(bus.mul_a), 32'd0);
    checkOutput("done_mul_b", 32'(bus.mul_b), 32'd0);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_product", 32'(bus.product), 32'(expP));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);

    bus.in_valid = 1'b0;
    checkOutput("ret_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("ret_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("ret_product", 32'(bus.product), 32'(expP));
    lastProduct = expP;
  endtask

  // Starts 0x77*0x88 and pulls reset asynchronously while in PP2.
  task automatic applyResetAbort();
    bus.in_valid  = 1'b1;
    bus.a         = 8'h77;
    bus.b         = 8'h88;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pp2_mul_a", 32'(bus.mul_a), 32'h7);
    checkOutput("abort_pp2_mul_b", 32'(bus.mul_b), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort_mul_a", 32'(bus.mul_a), 32'd0);
    checkOutput("abort_mul_b", 32'(bus.mul_b), 32'd0);
    checkOutput("abort_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lastProduct = 16'd0;
  endtask

  // Directed plan followed by randomized operations.
  initial begin
    total = 0;
    bad = 0;
    lastProduct = 16'd0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    bus.out_ready = 1'b1;
    #2;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_product", 32'(bus.product), 32'd0);
    checkOutput("rst_mul_a", 32'(bus.mul_a), 32'd0);
    checkOutput("rst_mul_b", 32'(bus.mul_b), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h0F, 8'h0F, 0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 0, 1'b0);
    applyStimulus(8'h12, 8'h34, 0, 1'b0);
    applyStimulus(8'hA5, 8'h3C, 4, 1'b0);
    applyStimulus(8'h5A, 8'hC3, 1, 1'b1);
    applyResetAbort();
    applyStimulus(8'h03, 8'h05, 0, 1'b0);
    applyStimulus(8'h00, 8'h37, 0, 1'b0);
    applyStimulus(8'h30, 8'h05, 0, 1'b0);
    applyStimulus(8'hF0, 8'h0F, 2, 1'b1);

    for (int r = 0; r < 24; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ra & 8'hF0;
      if ($urandom_range(0, 3) == 0) rb = rb & 8'h0F;
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
